// File: rtl/reg_bus_arbiter_pkg.sv
// reg_bus_arbiter_pkg
//   Shared definitions for the register-bus arbiter: the FSM state encoding,
//   the default downstream timeout and a small wrap-around index helper used
//   by the round-robin arbiter.
//   Optional feature macro used by the arbiter: REG_ARB_TIMEOUT_EN.
package reg_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WR_WAIT = 2'd1,
        ARB_RD_WAIT = 2'd2,
        ARB_DONE    = 2'd3
    } arb_state_e;

    localparam int ARB_TIMEOUT_DEF = 256;

    // Index reached by stepping 'offset' places forward from 'base' in a
    // ring of 'n' entries.
    function automatic int wrapIdx(input int base, input int offset, input int n);
        int sum;
        sum = base + offset;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_rr.sv
// rr_arbiter
//   Purely combinational round-robin pick: the first set request bit at or
//   after the pointer, wrapping NUM_REQ-1 -> 0.
//   Ports:
//     req_i       request vector, one bit per requester
//     ptr_i       index with highest priority this round
//     grant_o     one-hot grant (all zero when nothing requests)
//     grantIdx_o  binary index of the granted requester
//     valid_o     some requester was granted
module rr_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] grantIdx_o,
    output logic                       valid_o
);

    localparam int IW = $clog2(NUM_REQ);

    int cand;

    // Walk the ring starting at the pointer; the first requester met wins.
    always_comb begin
        grant_o    = '0;
        grantIdx_o = '0;
        valid_o    = 1'b0;
        cand       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrapIdx(int'(ptr_i), k, NUM_REQ);
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!valid_o && (j == cand) && req_i[j]) begin
                    valid_o    = 1'b1;
                    grant_o[j] = 1'b1;
                    grantIdx_o = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter
//   Shares one downstream register write/read port among NUM_REQ upstream
//   requesters. Round-robin grant, one transaction in flight, per-requester
//   one-cycle completion pulses.
//   Optional feature: define REG_ARB_TIMEOUT_EN to abort a transaction that
//   gets no downstream response within TIMEOUT_CYC cycles (req_err flags it).
//   Ports:
//     clk, resetn                      clock, async active-low reset
//     req_wen/waddr/wdata/wstrb        per-requester write request (level) + payload
//     req_wrdy                         per-requester write-done pulse
//     req_ren/raddr                    per-requester read request (level) + address
//     req_rdata, req_rrdy              shared read data, per-requester read-done pulse
//     req_err                          timeout flag qualifying a done pulse
//     m_reg_wen/waddr/wdata/wstrb      downstream write strobe + held payload
//     m_reg_wrdy                       downstream write done
//     m_reg_ren/raddr                  downstream read strobe + held address
//     m_reg_rdata, m_reg_rrdy          downstream read data + valid
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_REQ-1:0]      req_wen,
    input  logic [NUM_REQ*AW-1:0]   req_waddr,
    input  logic [NUM_REQ*DW-1:0]   req_wdata,
    input  logic [NUM_REQ*DW/8-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]      req_wrdy,
    input  logic [NUM_REQ-1:0]      req_ren,
    input  logic [NUM_REQ*AW-1:0]   req_raddr,
    output logic [DW-1:0]           req_rdata,
    output logic [NUM_REQ-1:0]      req_rrdy,
    output logic                    req_err,
    output logic                    m_reg_wen,
    output logic [AW-1:0]           m_reg_waddr,
    output logic [DW-1:0]           m_reg_wdata,
    output logic [DW/8-1:0]         m_reg_wstrb,
    input  logic                    m_reg_wrdy,
    output logic                    m_reg_ren,
    output logic [AW-1:0]           m_reg_raddr,
    input  logic [DW-1:0]           m_reg_rdata,
    input  logic                    m_reg_rrdy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = DW / 8;

    logic [NUM_REQ-1:0] reqVec;
    logic [NUM_REQ-1:0] grantOh;
    logic [IW-1:0]      grantIdx;
    logic               grantValid;
    logic [AW-1:0]      selWaddr;
    logic [DW-1:0]      selWdata;
    logic [SW-1:0]      selWstrb;
    logic [AW-1:0]      selRaddr;
    logic               selIsWrite;

    arb_state_e         state_q;
    logic [IW-1:0]      rrPtr_q;
    logic [IW-1:0]      owner_q;
    logic [NUM_REQ-1:0] ownerOh_q;
    logic               mWen_q;
    logic               mRen_q;
    logic [AW-1:0]      mWaddr_q;
    logic [DW-1:0]      mWdata_q;
    logic [SW-1:0]      mWstrb_q;
    logic [AW-1:0]      mRaddr_q;
    logic [DW-1:0]      rdata_q;
    logic [NUM_REQ-1:0] wrdy_q;
    logic [NUM_REQ-1:0] rrdy_q;

`ifdef REG_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CNT_LAST = CntW'(TIMEOUT_CYC - 1);
    logic [CntW-1:0] waitCnt_q;
    logic            err_q;
    assign req_err = err_q;
`else
    assign req_err = 1'b0;
`endif

    assign reqVec = req_wen | req_ren;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req_i      (reqVec),
        .ptr_i      (rrPtr_q),
        .grant_o    (grantOh),
        .grantIdx_o (grantIdx),
        .valid_o    (grantValid)
    );

    // Route the granted requester's payload. A requester asking for both
    // directions at once gets its write served first; the read stays pending
    // and is picked up by normal rotation.
    always_comb begin
        selWaddr   = '0;
        selWdata   = '0;
        selWstrb   = '0;
        selRaddr   = '0;
        selIsWrite = |(grantOh & req_wen);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantOh[i]) begin
                selWaddr = req_waddr[i*AW +: AW];
                selWdata = req_wdata[i*DW +: DW];
                selWstrb = req_wstrb[i*SW +: SW];
                selRaddr = req_raddr[i*AW +: AW];
            end
        end
    end

    // Transaction FSM. Strobes and done pulses default low every cycle so each
    // is exactly one cycle wide; payload registers hold until the next grant.
    // Downstream ready is only looked at in the wait states.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ARB_IDLE;
            rrPtr_q   <= '0;
            owner_q   <= '0;
            ownerOh_q <= '0;
            mWen_q    <= 1'b0;
            mRen_q    <= 1'b0;
            mWaddr_q  <= '0;
            mWdata_q  <= '0;
            mWstrb_q  <= '0;
            mRaddr_q  <= '0;
            rdata_q   <= '0;
            wrdy_q    <= '0;
            rrdy_q    <= '0;
`ifdef REG_ARB_TIMEOUT_EN
            waitCnt_q <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            mWen_q <= 1'b0;
            mRen_q <= 1'b0;
            wrdy_q <= '0;
            rrdy_q <= '0;
`ifdef REG_ARB_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                ARB_IDLE: begin
                    if (grantValid) begin
                        owner_q   <= grantIdx;
                        ownerOh_q <= grantOh;
`ifdef REG_ARB_TIMEOUT_EN
                        waitCnt_q <= '0;
`endif
                        if (selIsWrite) begin
                            mWaddr_q <= selWaddr;
                            mWdata_q <= selWdata;
                            mWstrb_q <= selWstrb;
                            mWen_q   <= 1'b1;
                            state_q  <= ARB_WR_WAIT;
                        end else begin
                            mRaddr_q <= selRaddr;
                            mRen_q   <= 1'b1;
                            state_q  <= ARB_RD_WAIT;
                        end
                    end
                end
                ARB_WR_WAIT: begin
                    if (m_reg_wrdy) begin
                        wrdy_q  <= ownerOh_q;
                        state_q <= ARB_DONE;
                    end
`ifdef REG_ARB_TIMEOUT_EN
                    else if (waitCnt_q == CNT_LAST) begin
                        wrdy_q  <= ownerOh_q;
                        err_q   <= 1'b1;
                        state_q <= ARB_DONE;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
`endif
                end
                ARB_RD_WAIT: begin
                    if (m_reg_rrdy) begin
                        rdata_q <= m_reg_rdata;
                        rrdy_q  <= ownerOh_q;
                        state_q <= ARB_DONE;
                    end
`ifdef REG_ARB_TIMEOUT_EN
                    else if (waitCnt_q == CNT_LAST) begin
                        rdata_q <= '0;
                        rrdy_q  <= ownerOh_q;
                        err_q   <= 1'b1;
                        state_q <= ARB_DONE;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
`endif
                end
                ARB_DONE: begin
                    rrPtr_q <= (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign m_reg_wen   = mWen_q;
    assign m_reg_ren   = mRen_q;
    assign m_reg_waddr = mWaddr_q;
    assign m_reg_wdata = mWdata_q;
    assign m_reg_wstrb = mWstrb_q;
    assign m_reg_raddr = mRaddr_q;
    assign req_rdata   = rdata_q;
    assign req_wrdy    = wrdy_q;
    assign req_rrdy    = rrdy_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter
//   Directed bench for reg_bus_arbiter with two requesters. Requester agents
//   hold their request levels until the matching done pulse; a slave model
//   answers strobes after a programmable delay. A transaction-level timeline
//   model predicts every output each cycle; literal checks pin key results.
//   Define REG_ARB_TIMEOUT_EN to also exercise the timeout path.
module tb_reg_bus_arbiter;

    localparam int NUM    = 2;
    localparam int TO_CYC = 16;
`ifdef REG_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [1:0]      req_wen = '0;
    logic [63:0]     req_waddr = '0;
    logic [63:0]     req_wdata = '0;
    logic [7:0]      req_wstrb = '0;
    logic [1:0]      req_wrdy;
    logic [1:0]      req_ren = '0;
    logic [63:0]     req_raddr = '0;
    logic [31:0]     req_rdata;
    logic [1:0]      req_rrdy;
    logic            req_err;
    logic            m_reg_wen;
    logic [31:0]     m_reg_waddr;
    logic [31:0]     m_reg_wdata;
    logic [3:0]      m_reg_wstrb;
    logic            m_reg_wrdy = 1'b0;
    logic            m_reg_ren;
    logic [31:0]     m_reg_raddr;
    logic [31:0]     m_reg_rdata = '0;
    logic            m_reg_rrdy = 1'b0;

    int totalCount = 0;
    int badCount = 0;
    int cyc = 0;

    typedef struct {
        bit          w;
        bit          r;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] raddr;
    } op_t;

    typedef struct {
        int          cyc;
        int          idx;
        bit          w;
        logic [31:0] rdata;
        logic        err;
    } comp_t;

    typedef struct {
        int          cyc;
        bit          w;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } strb_t;

    op_t   opQ[NUM][$];
    comp_t compLog[$];
    strb_t strbLog[$];
    logic [31:0] slaveData[$];

    int  slaveWait = 0;
    bit  slaveMute = 1'b0;
    bit  spurious = 1'b0;

    reg_bus_arbiter #(
        .NUM_REQ(NUM), .AW(32), .DW(32), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_wen(req_wen), .req_waddr(req_waddr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .req_wrdy(req_wrdy),
        .req_ren(req_ren), .req_raddr(req_raddr), .req_rdata(req_rdata),
        .req_rrdy(req_rrdy), .req_err(req_err),
        .m_reg_wen(m_reg_wen), .m_reg_waddr(m_reg_waddr), .m_reg_wdata(m_reg_wdata),
        .m_reg_wstrb(m_reg_wstrb), .m_reg_wrdy(m_reg_wrdy),
        .m_reg_ren(m_reg_ren), .m_reg_raddr(m_reg_raddr), .m_reg_rdata(m_reg_rdata),
        .m_reg_rrdy(m_reg_rrdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCount++;
        if (act !== exp) begin
            badCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int who, input bit w, input bit r,
                                 input logic [31:0] waddr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input logic [31:0] raddr);
        op_t op;
        op.w = w; op.r = r; op.waddr = waddr; op.wdata = wdata; op.wstrb = wstrb; op.raddr = raddr;
        opQ[who].push_back(op);
    endtask

    task automatic waitComp(input int n, input int budget);
        int b;
        b = 0;
        while (compLog.size() < n && b < budget) begin
            @(posedge clk); #2;
            b++;
        end
        if (compLog.size() < n) begin
            totalCount++;
            badCount++;
            $display("[TB] FAIL wait_completion: got %0d completions, required %0d", compLog.size(), n);
        end
    endtask

    task automatic waitStrobe(input int n, input int budget);
        int b;
        b = 0;
        while (strbLog.size() < n && b < budget) begin
            @(posedge clk); #2;
            b++;
        end
        if (strbLog.size() < n) begin
            totalCount++;
            badCount++;
            $display("[TB] FAIL wait_strobe: got %0d strobes, required %0d", strbLog.size(), n);
        end
    endtask

    // Requester agents: keep each level up until its own done pulse, then load
    // the next queued operation straight away.
    always begin
        op_t op;
        @(posedge clk); #1;
        for (int i = 0; i < NUM; i++) begin
            if (req_wen[i] && req_wrdy[i]) req_wen[i] = 1'b0;
            if (req_ren[i] && req_rrdy[i]) req_ren[i] = 1'b0;
            if (!req_wen[i] && !req_ren[i] && opQ[i].size() > 0) begin
                op = opQ[i].pop_front();
                req_wen[i] = op.w;
                req_ren[i] = op.r;
                req_waddr[i*32 +: 32] = op.waddr;
                req_wdata[i*32 +: 32] = op.wdata;
                req_wstrb[i*4 +: 4]   = op.wstrb;
                req_raddr[i*32 +: 32] = op.raddr;
            end
        end
    end

    // Slave: answers slaveWait cycles after the strobe cycle (0 = same cycle).
    always begin
        bit pendW;
        bit pendR;
        int cnt;
        @(posedge clk); #1;
        m_reg_wrdy = 1'b0;
        m_reg_rrdy = 1'b0;
        if (!resetn || slaveMute) begin
            pendW = 1'b0;
            pendR = 1'b0;
        end else begin
            if (m_reg_wen || m_reg_ren) begin
                pendW = m_reg_wen;
                pendR = m_reg_ren;
                cnt = 0;
            end
            if (pendW || pendR) begin
                if (cnt == slaveWait) begin
                    if (pendW) begin
                        m_reg_wrdy = 1'b1;
                    end else begin
                        m_reg_rrdy = 1'b1;
                        m_reg_rdata = (slaveData.size() > 0) ? slaveData.pop_front() : 32'hDEAD_BEEF;
                    end
                    pendW = 1'b0;
                    pendR = 1'b0;
                end else begin
                    cnt++;
                end
            end else if (spurious) begin
                m_reg_wrdy = 1'b1;
                m_reg_rrdy = 1'b1;
                m_reg_rdata = 32'hBAD0_0BAD;
                spurious = 1'b0;
            end
        end
    end

    // Timeline model: a granted transaction strobes the cycle after the grant,
    // completes the cycle after the slave answers, and the port is free again
    // one cycle after the completion pulse.
    bit          mBusy = 1'b0;
    bit          mIsW = 1'b0;
    bit          mTimedOut = 1'b0;
    int          mOwner = 0;
    int          mPtr = 0;
    int          mStrobe = -1;
    int          mPulse = -1;
    int          mFree = 0;
    logic [31:0] mWaddr = '0, mWdata = '0, mRaddr = '0, mRdata = '0;
    logic [3:0]  mWstrb = '0;

    always @(negedge clk) begin
        bit   pulse;
        bit   found;
        int   j;
        logic [1:0] eW, eR;
        if (!resetn) begin
            checkOutput("rst_m_wen", m_reg_wen, 0);
            checkOutput("rst_m_ren", m_reg_ren, 0);
            checkOutput("rst_m_waddr", m_reg_waddr, 0);
            checkOutput("rst_m_wdata", m_reg_wdata, 0);
            checkOutput("rst_m_wstrb", m_reg_wstrb, 0);
            checkOutput("rst_m_raddr", m_reg_raddr, 0);
            checkOutput("rst_wrdy", req_wrdy, 0);
            checkOutput("rst_rrdy", req_rrdy, 0);
            checkOutput("rst_rdata", req_rdata, 0);
            checkOutput("rst_err", req_err, 0);
            mBusy = 1'b0; mPtr = 0; mFree = 0; mPulse = -1; mStrobe = -1;
            mWaddr = '0; mWdata = '0; mWstrb = '0; mRaddr = '0; mRdata = '0;
        end else begin
            pulse = mBusy && (cyc == mPulse);
            eW = (pulse && mIsW) ? (2'b01 << mOwner) : 2'b00;
            eR = (pulse && !mIsW) ? (2'b01 << mOwner) : 2'b00;
            checkOutput("m_wen", m_reg_wen, mBusy && mIsW && (cyc == mStrobe));
            checkOutput("m_ren", m_reg_ren, mBusy && !mIsW && (cyc == mStrobe));
            checkOutput("m_waddr", m_reg_waddr, mWaddr);
            checkOutput("m_wdata", m_reg_wdata, mWdata);
            checkOutput("m_wstrb", m_reg_wstrb, mWstrb);
            checkOutput("m_raddr", m_reg_raddr, mRaddr);
            checkOutput("req_wrdy", req_wrdy, eW);
            checkOutput("req_rrdy", req_rrdy, eR);
            checkOutput("req_rdata", req_rdata, mRdata);
            checkOutput("req_err", req_err, pulse && mTimedOut);

            if (m_reg_wen || m_reg_ren)
                strbLog.push_back('{cyc: cyc, w: m_reg_wen,
                                    addr: m_reg_wen ? m_reg_waddr : m_reg_raddr,
                                    data: m_reg_wdata, strb: m_reg_wstrb});
            if ((req_wrdy | req_rrdy) != 2'b00)
                compLog.push_back('{cyc: cyc,
                                    idx: ((req_wrdy | req_rrdy) == 2'b01) ? 0 :
                                         ((req_wrdy | req_rrdy) == 2'b10) ? 1 : 9,
                                    w: (req_wrdy != 2'b00), rdata: req_rdata, err: req_err});

            found = 1'b0;
            j = 0;
            if (pulse) begin
                mBusy = 1'b0;
                mPtr = (mOwner + 1) % NUM;
                mFree = cyc + 1;
            end else if (mBusy && mPulse < 0 && cyc >= mStrobe) begin
                if (mIsW ? m_reg_wrdy : m_reg_rrdy) begin
                    mPulse = cyc + 1;
                    if (!mIsW) mRdata = m_reg_rdata;
                end else if (TO_EN && (cyc - mStrobe + 1) == TO_CYC) begin
                    mPulse = cyc + 1;
                    mTimedOut = 1'b1;
                    if (!mIsW) mRdata = '0;
                end
            end else if (!mBusy && cyc >= mFree) begin
                for (int k = 0; k < NUM; k++) begin
                    j = (mPtr + k) % NUM;
                    if (!found && (req_wen[j] || req_ren[j])) begin
                        found = 1'b1;
                        mBusy = 1'b1;
                        mOwner = j;
                        mIsW = req_wen[j];
                        mStrobe = cyc + 1;
                        mPulse = -1;
                        mTimedOut = 1'b0;
                        if (mIsW) begin
                            mWaddr = req_waddr[j*32 +: 32];
                            mWdata = req_wdata[j*32 +: 32];
                            mWstrb = req_wstrb[j*4 +: 4];
                        end else begin
                            mRaddr = req_raddr[j*32 +: 32];
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", badCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        int s0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_wen", m_reg_wen, 0);
        checkOutput("reset_rdata", req_rdata, 0);
        resetn = 1'b1;

        // Single write with a two-cycle slave.
        $display("[TB] single write");
        slaveWait = 2;
        applyStimulus(0, 1, 0, 32'h10, 32'hA5A5_0001, 4'hF, 32'h0);
        waitComp(1, 50);
        waitStrobe(1, 5);
        if (compLog.size() >= 1 && strbLog.size() >= 1) begin
            checkOutput("t1_strobe_is_write", strbLog[0].w, 1);
            checkOutput("t1_waddr", strbLog[0].addr, 32'h10);
            checkOutput("t1_wdata", strbLog[0].data, 32'hA5A5_0001);
            checkOutput("t1_wstrb", strbLog[0].strb, 4'hF);
            checkOutput("t1_owner", compLog[0].idx, 0);
            checkOutput("t1_is_write", compLog[0].w, 1);
            checkOutput("t1_latency", compLog[0].cyc - strbLog[0].cyc, 3);
        end

        // Spurious downstream ready while idle must do nothing.
        spurious = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        checkOutput("spurious_no_comp", compLog.size(), 1);
        checkOutput("spurious_no_strobe", strbLog.size(), 1);

        // Fresh reset so the rotation pointer starts at 0.
        @(posedge clk); #3 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Contention: both read in the same cycle.
        $display("[TB] contention");
        c0 = compLog.size();
        s0 = strbLog.size();
        slaveWait = 1;
        slaveData.push_back(32'h11);
        slaveData.push_back(32'h22);
        applyStimulus(0, 0, 1, 0, 0, 0, 32'h100);
        applyStimulus(1, 0, 1, 0, 0, 0, 32'h104);
        waitComp(c0 + 2, 60);
        if (compLog.size() >= c0 + 2 && strbLog.size() >= s0 + 2) begin
            checkOutput("t2_first_owner", compLog[c0].idx, 0);
            checkOutput("t2_first_rdata", compLog[c0].rdata, 32'h11);
            checkOutput("t2_second_owner", compLog[c0+1].idx, 1);
            checkOutput("t2_second_rdata", compLog[c0+1].rdata, 32'h22);
            checkOutput("t2_first_raddr", strbLog[s0].addr, 32'h100);
            checkOutput("t2_second_raddr", strbLog[s0+1].addr, 32'h104);
        end

        // Fairness: both hold writes continuously.
        $display("[TB] fairness");
        c0 = compLog.size();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 0, 32'h200 + 32'(k*4), 32'h1000 + 32'(k), 4'h1, 0);
            applyStimulus(1, 1, 0, 32'h300 + 32'(k*4), 32'h2000 + 32'(k), 4'h8, 0);
        end
        waitComp(c0 + 8, 200);
        if (compLog.size() >= c0 + 8) begin
            for (int k = 0; k < 8; k++) begin
                checkOutput("t3_alternation", compLog[c0+k].idx, k % 2);
            end
        end

        // Same requester write+read against a zero-wait slave.
        $display("[TB] write plus read");
        c0 = compLog.size();
        s0 = strbLog.size();
        slaveWait = 0;
        slaveData.push_back(32'h44);
        applyStimulus(0, 1, 1, 32'h400, 32'hCAFE_0004, 4'h3, 32'h404);
        waitComp(c0 + 2, 50);
        if (compLog.size() >= c0 + 2 && strbLog.size() >= s0 + 2) begin
            checkOutput("t4_write_first", compLog[c0].w, 1);
            checkOutput("t4_read_second", compLog[c0+1].w, 0);
            checkOutput("t4_read_rdata", compLog[c0+1].rdata, 32'h44);
            checkOutput("t4_strobe_spacing", strbLog[s0+1].cyc - strbLog[s0].cyc, 3);
        end

        // Reset while a read waits on a silent slave.
        $display("[TB] reset mid-transaction");
        c0 = compLog.size();
        s0 = strbLog.size();
        slaveMute = 1'b1;
        applyStimulus(1, 0, 1, 0, 0, 0, 32'h500);
        waitStrobe(s0 + 1, 20);
        repeat (2) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        checkOutput("t5_ren_low", m_reg_ren, 0);
        checkOutput("t5_raddr_zero", m_reg_raddr, 0);
        checkOutput("t5_rdata_zero", req_rdata, 0);
        slaveMute = 1'b0;
        slaveData.push_back(32'h55);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        checkOutput("t5_no_pulse", compLog.size(), c0);
        waitComp(c0 + 1, 50);
        if (compLog.size() >= c0 + 1) begin
            checkOutput("t5_owner", compLog[c0].idx, 1);
            checkOutput("t5_rdata", compLog[c0].rdata, 32'h55);
        end

`ifdef REG_ARB_TIMEOUT_EN
        $display("[TB] timeout");
        c0 = compLog.size();
        s0 = strbLog.size();
        slaveMute = 1'b1;
        applyStimulus(0, 0, 1, 0, 0, 0, 32'h600);
        waitComp(c0 + 1, 100);
        if (compLog.size() >= c0 + 1 && strbLog.size() >= s0 + 1) begin
            checkOutput("t6_err", compLog[c0].err, 1);
            checkOutput("t6_rdata", compLog[c0].rdata, 0);
            checkOutput("t6_wait", compLog[c0].cyc - strbLog[s0].cyc, 16);
        end
        slaveMute = 1'b0;
        applyStimulus(1, 1, 0, 32'h700, 32'h7777_0007, 4'hF, 0);
        waitComp(c0 + 2, 50);
        if (compLog.size() >= c0 + 2) begin
            checkOutput("t6_next_err", compLog[c0+1].err, 0);
            checkOutput("t6_next_owner", compLog[c0+1].idx, 1);
        end
`endif

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
